writeback_queue: RTL
====================

# writeback_queue

Buffers register-file write-back results from the ALU and the load unit and drives the register file's single write port (rw/addr3/data3), one write per clock. It is the writer side of the register-file write interface. Two producers can post results in the same cycle without losing either. A forwarding query port returns the youngest pending value for any register that has not yet been written.

## Interface
- DEPTH, 4: number of pending write entries (power of two, ≥2)
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous, active-high reset
- alu_valid  in  1  ALU result offered this cycle
- alu_addr  in  5  ALU destination register
- alu_data  in  32  ALU result value
- alu_ready  out  1  ALU result accepted at next posedge when alu_valid=1
- mem_valid  in  1  load result offered this cycle
- mem_addr  in  5  load destination register
- mem_data  in  32  load result value
- mem_ready  out  1  load result accepted at next posedge when mem_valid=1
- rw  out  1  write enable to register file (registered)
- addr3  out  5  write address to register file (registered)
- data3  out  32  write data to register file (registered)
- q_addr  in  5  forwarding query register
- q_hit  out  1  pending or in-flight write to q_addr exists (combinational)
- q_data  out  32  youngest pending value for q_addr; 0 when q_hit=0
- count  out  log2(DEPTH)+1  entries in FIFO (excludes output register)

## Operation
- Storage: circular FIFO of DEPTH entries {addr[4:0], data[31:0]}, with wr_ptr, rd_ptr and count. Pointers wrap modulo DEPTH.
- free = DEPTH − count. Computed from the current count only; a pop in the same cycle does not create extra space.
- mem_ready = (free ≥ 1).
- alu_ready = (free ≥ 2) when mem_valid=1; otherwise alu_ready = (free ≥ 1).
- Load results take priority for space; the ALU stalls when only one slot is free and both producers are valid.
- Enqueue order when both are accepted: the mem entry goes at wr_ptr and the alu entry at wr_ptr+1. The ALU entry is therefore the younger.
- Pop: at each posedge with count>0, the head entry is loaded into the output register with rw=1, and rd_ptr advances. With count=0, rw←0 and addr3/data3 hold their previous values.
- Push and pop on the same edge: count_next = count + pushes − pop. count never exceeds DEPTH.
- Register 0 is an ordinary register and is written like any other. No discard for addr 0.
- Forwarding search order, youngest first:
  - FIFO entries, from wr_ptr−1 down to rd_ptr.
  - Then the output register, if rw=1.
  - The first match gives q_hit=1 and q_data=that data.
- Entries being offered on alu_*/mem_* in the current cycle are not searched.
- Reset: count=0, wr_ptr=rd_ptr=0, rw=0, addr3=0, data3=0. This gives q_hit=0, q_data=0, alu_ready=mem_ready=1. Any pending entries are dropped with no write issued. Reset overrides a simultaneous push or pop.

## Timing
- Result accepted at posedge k → rw=1 with that entry from posedge k+1 (if it is the head) to posedge k+2. The register file commits it on the negedge inside that cycle.
- Minimum latency from valid to committed write: 1 edge into FIFO, 1 edge into output register, half a cycle to the negedge write.
- Throughput: 1 write per cycle sustained; 2 accepts per cycle while free ≥ 2.
- rw, addr3 and data3 change only on posedge, so they are stable at the register file's negedge write.
- q_hit and q_data are combinational from q_addr, FIFO state and the output register, with no added cycle.

## Test plan
- Reset, then single ALU push of addr=5, data=0x1234 → alu_ready=1; count=1 after edge 1; rw=1, addr3=5, data3=0x1234 during the cycle after edge 2; count=0; rw=0 the cycle after.
- Both producers valid with count=0: mem {3, 0xAAAA}, alu {3, 0xBBBB} → both accepted. Writes appear in order addr3=3/0xAAAA, then 3/0xBBBB. q_addr=3 gives 0xBBBB while both are pending, and gives 0xBBBB while only the second is in the output register.
- Both producers valid with count=DEPTH−1 (3) → mem_ready=1, alu_ready=0. After the edge, count=3 (one push, one pop). The ALU is accepted on the next cycle.
- Fill to count=4, then hold both valid → alu_ready=mem_ready=0. Drain gives exactly 4 writes in FIFO order. Pointer wrap is verified by 3 consecutive fill/drain rounds with no data corruption.
- Forwarding: pending writes to r7 of 0x1 and then 0x2, query r7 → q_hit=1, q_data=0x2. Query r8 → q_hit=0, q_data=0. Query addr 0 after a pending write to r0 of 0x55 → hit, 0x55.
- Assert rst with count=3 and rw=1 → on the next edge count=0 and rw=0, no further writes issue, and the ready signals return to 1.

Source files
------------

// File: rtl/writeback_queue_if.sv
// Write-back queue bus: producer offers (ALU and load unit), the register-file
// write port, the forwarding query port and the occupancy count.
// master: producers / register-file side. slave: the queue itself.
interface writeback_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic          alu_valid;
  logic [4:0]    alu_addr;
  logic [31:0]   alu_data;
  logic          alu_ready;

  logic          mem_valid;
  logic [4:0]    mem_addr;
  logic [31:0]   mem_data;
  logic          mem_ready;

  logic          rw;
  logic [4:0]    addr3;
  logic [31:0]   data3;

  logic [4:0]    q_addr;
  logic          q_hit;
  logic [31:0]   q_data;

  logic [CW-1:0] count;

  modport master (
    output alu_valid, alu_addr, alu_data,
    input  alu_ready,
    output mem_valid, mem_addr, mem_data,
    input  mem_ready,
    input  rw, addr3, data3,
    output q_addr,
    input  q_hit, q_data,
    input  count
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    output alu_ready,
    input  mem_valid, mem_addr, mem_data,
    output mem_ready,
    output rw, addr3, data3,
    input  q_addr,
    output q_hit, q_data,
    output count
  );
endinterface

// File: rtl/writeback_queue.sv
// Register-file write-back queue: accepts up to two results per cycle (load
// result first, ALU result second), drains one registered write per cycle and
// forwards the youngest pending value for a queried register.
module writeback_queue #(
  parameter int unsigned DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  writeback_queue_if.slave  bus
);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  typedef struct packed {
    logic [4:0]  addr;
    logic [31:0] data;
  } entry_t;

  entry_t        fifo [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] count_q;

  logic          rw_q;
  logic [4:0]    addr3_q;
  logic [31:0]   data3_q;

  logic [CW-1:0] free_c;
  logic          mem_ready_c;
  logic          alu_ready_c;
  logic          mem_push_c;
  logic          alu_push_c;
  logic          pop_c;
  logic [PW-1:0] alu_slot_c;
  logic          q_hit_c;
  logic [31:0]   q_data_c;

  // Space check from current occupancy only; the load unit wins the last slot
  always_comb begin
    free_c      = CW'(DEPTH) - count_q;
    mem_ready_c = (free_c >= CW'(1));
    alu_ready_c = bus.mem_valid ? (free_c >= CW'(2)) : (free_c >= CW'(1));
    mem_push_c  = bus.mem_valid & mem_ready_c;
    alu_push_c  = bus.alu_valid & alu_ready_c;
    pop_c       = (count_q != '0);
    alu_slot_c  = wr_ptr + PW'(mem_push_c);
  end

  // Entry storage; stale contents are never observed because count gates every read
  always_ff @(posedge clk) begin
    if (mem_push_c) fifo[wr_ptr]     <= {bus.mem_addr, bus.mem_data};
    if (alu_push_c) fifo[alu_slot_c] <= {bus.alu_addr, bus.alu_data};
  end

  // Pointers, occupancy and the registered register-file write port
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      rw_q    <= 1'b0;
      addr3_q <= '0;
      data3_q <= '0;
    end else begin
      wr_ptr  <= wr_ptr + PW'(mem_push_c) + PW'(alu_push_c);
      count_q <= count_q + CW'(mem_push_c) + CW'(alu_push_c) - CW'(pop_c);
      if (pop_c) begin
        rw_q    <= 1'b1;
        addr3_q <= fifo[rd_ptr].addr;
        data3_q <= fifo[rd_ptr].data;
        rd_ptr  <= rd_ptr + PW'(1);
      end else begin
        rw_q    <= 1'b0;
      end
    end
  end

  // Forwarding: scan oldest to youngest so the youngest match is the one left standing
  always_comb begin
    q_hit_c  = 1'b0;
    q_data_c = '0;
    if (rw_q && (addr3_q == bus.q_addr)) begin
      q_hit_c  = 1'b1;
      q_data_c = data3_q;
    end
    for (int unsigned j = 0; j < DEPTH; j++) begin
      if ((CW'(j) < count_q) && (fifo[rd_ptr + PW'(j)].addr == bus.q_addr)) begin
        q_hit_c  = 1'b1;
        q_data_c = fifo[rd_ptr + PW'(j)].data;
      end
    end
  end

  assign bus.alu_ready = alu_ready_c;
  assign bus.mem_ready = mem_ready_c;
  assign bus.rw        = rw_q;
  assign bus.addr3     = addr3_q;
  assign bus.data3     = data3_q;
  assign bus.q_hit     = q_hit_c;
  assign bus.q_data    = q_data_c;
  assign bus.count     = count_q;
endmodule
